// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: widths, the NOP
// encoding, the fetch entry layout, FSM state encodings and fault detection.
package instr_fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FE_W = 65;  // {fault, pc[31:0], instr[31:0]}

  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic            fault;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // A fetch faults when the PC is misaligned or indexes past the end of IMEM.
  function automatic logic is_fetch_fault(input logic [XLEN-1:0] pc,
                                          input int unsigned      words);
    return (pc[1:0] != 2'b00) || (pc[XLEN-1:2] >= 30'(words));
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_fetch_fifo.sv
// fetch_fifo: 2-entry in-order FIFO of fetch entries with a registered head.
//  clk, reset : clock, synchronous active-high reset (clears entries and head)
//  push, din  : enqueue din
//  pop        : dequeue head (caller guarantees count != 0)
//  flush      : discard all entries; priority over push/pop; head value kept
//  dout       : head entry
//  count      : number of valid entries (0..2)
module fetch_fifo
  import instr_fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [FE_W-1:0] din,
  output logic [FE_W-1:0] dout,
  output logic [1:0]      count
);

  logic [FE_W-1:0] head_q;
  logic [FE_W-1:0] tail_q;
  logic [1:0]      count_q;

  assign dout  = head_q;
  assign count = count_q;

  // Entry 0 lives in head_q so dout is always a flop output.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else if (push && pop && (count_q != 2'd0)) begin
      if (count_q == 2'd2) begin
        head_q <= tail_q;
        tail_q <= din;
      end else begin
        head_q <= din;
      end
    end else if (push) begin
      if (count_q == 2'd0) begin
        head_q  <= din;
        count_q <= 2'd1;
      end else if (count_q == 2'd1) begin
        tail_q  <= din;
        count_q <= 2'd2;
      end
    end else if (pop && (count_q != 2'd0)) begin
      if (count_q == 2'd2) head_q <= tail_q;
      count_q <= count_q - 2'd1;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: owns the PC, reads the combinational IMEM port, buffers
// fetched words in a 2-entry FIFO and hands them to decode via valid/ready.
//  clk, reset      : clock, synchronous active-high reset
//  imem_addr       : byte address to IMEM (current PC)
//  imem_data       : IMEM read data for imem_addr, same cycle
//  redirect_valid  : execute requests a PC change; flushes the buffer
//  redirect_pc     : redirect target (misaligned targets fault on fetch)
//  out_valid/ready : head handshake to decode
//  out_pc/instr    : head entry PC and instruction (NOP on fault)
//  out_fault       : head entry is a fetch fault
//  busy_halted     : fetcher stopped after pushing a fault entry
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault,
  output logic        busy_halted
);

  logic [31:0]     pc_q;
  fetch_state_e    state_q;
  logic [1:0]      count;
  logic [FE_W-1:0] head_bits;
  fetch_entry_t    head;
  fetch_entry_t    entry;
  logic            flt;
  logic            pop;
  logic            push;

  assign imem_addr = pc_q;

  // Fault detect, handshake decode and entry assembly.
  always_comb begin
    flt         = is_fetch_fault(pc_q, IMEM_WORDS);
    pop         = (count != 2'd0) && out_ready && !redirect_valid && !reset;
    push        = (state_q == FS_RUN) && !redirect_valid && !reset &&
                  ((count < 2'd2) || pop);
    entry.fault = flt;
    entry.pc    = pc_q;
    entry.instr = flt ? INSTR_NOP : imem_data;
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (FE_W'(entry)),
    .dout  (head_bits),
    .count (count)
  );

  // PC and RUN/HALT state. A faulting fetch leaves the PC on the faulting address.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= FS_RUN;
    end else if (redirect_valid) begin
      pc_q    <= redirect_pc;
      state_q <= FS_RUN;
    end else if (push) begin
      if (flt) state_q <= FS_HALT;
      else     pc_q    <= pc_q + 32'd4;
    end
  end

  assign head        = fetch_entry_t'(head_bits);
  assign out_valid   = (count != 2'd0);
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_fault   = head.fault;
  assign busy_halted = (state_q == FS_HALT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios followed by random
// ready/redirect/reset traffic, checked against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned WORDS  = 64;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
  logic        busy_halted;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.RESET_PC(RST_PC), .IMEM_WORDS(WORDS)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault),
    .busy_halted    (busy_halted)
  );

  // IMEM contents: word i holds 0x1000_0000 + i; beyond the end it is garbage.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    longint unsigned idx;
    idx = longint'(a) / 4;
    if (idx < WORDS) return 32'h1000_0000 + 32'(idx);
    return 32'hBAD0_0000 ^ a;
  endfunction

  always_comb imem_data = reset ? 32'h0 : mem_word(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          flt;
  } exp_t;

  int          checks = 0;
  int          fails  = 0;
  string       phase  = "init";
  exp_t        q[$];
  logic [31:0] m_pc    = 32'h0;
  bit          m_halt  = 1'b0;
  bit          m_known = 1'b0;
  bit          m_fresh = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, compare DUT state with the model, advance the model.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc, input bit rst);
    exp_t e;
    bit   popd;
    bit   can;
    bit   bad;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    reset          = rst;
    #1;
    if (m_known) begin
      chk("valid", 32'(out_valid), 32'(q.size() != 0));
      chk("imem_addr", imem_addr, m_pc);
      chk("halted", 32'(busy_halted), 32'(m_halt));
      if (q.size() != 0) begin
        chk("pc", out_pc, q[0].pc);
        chk("instr", out_instr, q[0].instr);
        chk("fault", 32'(out_fault), 32'(q[0].flt));
      end else if (m_fresh) begin
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_fault", 32'(out_fault), 32'h0);
      end
    end
    if (rst) begin
      q.delete();
      m_pc    = RST_PC;
      m_halt  = 1'b0;
      m_fresh = 1'b1;
      m_known = 1'b1;
    end else if (m_known) begin
      if (rv) begin
        q.delete();
        m_pc   = rpc;
        m_halt = 1'b0;
      end else begin
        popd = (q.size() != 0) && rdy;
        can  = !m_halt && ((q.size() < 2) || popd);
        if (popd) void'(q.pop_front());
        if (can) begin
          bad     = (m_pc % 4 != 0) || (longint'(m_pc) / 4 >= WORDS);
          e.pc    = m_pc;
          e.flt   = bad;
          e.instr = bad ? NOP : mem_word(m_pc);
          q.push_back(e);
          m_fresh = 1'b0;
          if (bad) m_halt = 1'b1;
          else     m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(rdy, 1'b0, 32'h0, 1'b0);
  endtask

  logic [31:0] targets [8];

  initial begin
    targets[0] = 32'h0000_0000; targets[1] = 32'h0000_0040;
    targets[2] = 32'h0000_00F8; targets[3] = 32'h0000_00FC;
    targets[4] = 32'h0000_0100; targets[5] = 32'h0000_0006;
    targets[6] = 32'hFFFF_FFFC; targets[7] = 32'h0000_0080;

    phase = "s1_stream";
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    idle(1'b1, 6);

    phase = "s2_stall";
    step(1'b0, 1'b0, 32'h0, 1'b1);
    idle(1'b0, 4);
    idle(1'b1, 4);

    phase = "s3_redirect";
    step(1'b0, 1'b0, 32'h0, 1'b1);
    idle(1'b0, 2);
    idle(1'b1, 2);
    step(1'b1, 1'b1, 32'h0000_0040, 1'b0);
    idle(1'b1, 4);

    phase = "s4_end_of_mem";
    step(1'b1, 1'b1, 32'h0000_00FC, 1'b0);
    idle(1'b1, 5);
    step(1'b1, 1'b1, 32'h0000_0000, 1'b0);
    idle(1'b1, 3);

    phase = "s5_misaligned";
    step(1'b1, 1'b1, 32'h0000_0006, 1'b0);
    idle(1'b1, 4);

    phase = "s6_reset_full";
    step(1'b1, 1'b1, 32'h0000_0020, 1'b0);
    idle(1'b0, 3);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    idle(1'b1, 4);

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      bit          r_rdy;
      bit          r_rv;
      bit          r_rst;
      logic [31:0] r_pc;
      r_rdy = ($urandom % 4) != 0;
      r_rv  = ($urandom % 12) == 0;
      r_rst = ($urandom % 90) == 0;
      if (($urandom % 3) == 0) r_pc = 32'($urandom_range(0, 63)) << 2;
      else                     r_pc = targets[$urandom % 8];
      step(r_rdy, r_rv, r_pc, r_rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
